sap_core: RTL and testbench

Parametrised successor to the 8-bit SAP-style CPU: a single-clock, single-edge microcoded accumulator core with configurable data and address widths. It has a flags register, conditional jumps, variable-length instructions with early step-counter reset, and a program-load port for the internal RAM. It sits at the top of the design in place of the fixed 8-bit CPU and is driven only by clock, reset and the load port.

---
 rtl/sap_pkg.sv | 62 ++++++
 rtl/sap_ram.sv | 32 +++
 rtl/sap_core.sv | 235 +++++++++++++++++++++++
 tb/tb_sap_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the sap_core microcoded accumulator CPU:
// opcodes, step encoding and control-word bit positions.
package sap_pkg;

    // Opcodes live in the top nibble of the instruction word
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Microcode step counter
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    // Control-word bit indices. Bus drivers: co, io, ro, ao, eo.
    localparam int CW_MI  = 0;   // MAR <- bus
    localparam int CW_RI  = 1;   // RAM[MAR] <- bus
    localparam int CW_RO  = 2;   // bus <- RAM[MAR]
    localparam int CW_II  = 3;   // IR <- bus
    localparam int CW_AI  = 4;   // A <- bus
    localparam int CW_BI  = 5;   // B <- bus
    localparam int CW_EO  = 6;   // bus <- ALU
    localparam int CW_SU  = 7;   // ALU subtracts
    localparam int CW_OI  = 8;   // OUT <- bus
    localparam int CW_CE  = 9;   // PC increment
    localparam int CW_J   = 10;  // PC <- bus
    localparam int CW_FI  = 11;  // flags <- ALU
    localparam int CW_HLT = 12;  // halt
    localparam int CW_CO  = 13;  // bus <- PC
    localparam int CW_IO  = 14;  // bus <- IR operand
    localparam int CW_AO  = 15;  // bus <- A
    localparam int CW_END = 16;  // last step of this instruction
    localparam int CW_W   = 17;

    typedef logic [CW_W-1:0] cw_t;

    // Plain successor step; the END bit overrides it back to T0
    function automatic step_e step_next(input step_e s);
        step_e n;
        case (s)
            T0:      n = T1;
            T1:      n = T2;
            T2:      n = T3;
            T3:      n = T4;
            default: n = T0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM for sap_core: one write port shared between the core
// (STA) and the external program-load port, one combinational read port
// addressed by the registered MAR.
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_data_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Single write port; the core wins, though both never fire together
    always_ff @(posedge clk_i) begin
        if (core_we_i) begin
            mem_q[core_addr_i] <= core_data_i;
        end else if (prog_we_i) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap_core.sv
// sap_core: parametrised SAP-style microcoded accumulator CPU.
// Optional feature macro: SAP_CORE_CONDJMP_EN enables JC/JZ; when it is
// undefined opcodes 0x7/0x8 decode as NOP (flags still computed).
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] a_o,
    output logic              cf,
    output logic              zf
);

    localparam int PAD_W = DATA_W - ADDR_W;

    step_e             step_q, step_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [3:0]        op_q, op_d;    // IR opcode field
    logic [ADDR_W-1:0] arg_q, arg_d;  // IR operand field (middle bits dropped)
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cf_q, cf_d;
    logic              zf_q, zf_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;
    logic              halted_q, halted_d;

    cw_t               cw;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W:0]   alu_sum;
    logic              prog_ok;

    // Microcode decode from {opcode, step}; a halted core issues nothing
    always_comb begin
        cw = '0;
        case (step_q)
            T0: begin
                cw[CW_CO] = 1'b1;
                cw[CW_MI] = 1'b1;
            end
            T1: begin
                cw[CW_RO] = 1'b1;
                cw[CW_II] = 1'b1;
                cw[CW_CE] = 1'b1;
            end
            T2: begin
                case (op_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IO] = 1'b1;
                        cw[CW_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IO]  = 1'b1;
                        cw[CW_AI]  = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IO]  = 1'b1;
                        cw[CW_J]   = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
`ifdef SAP_CORE_CONDJMP_EN
                    OP_JC: begin
                        cw[CW_IO]  = cf_q;
                        cw[CW_J]   = cf_q;
                        cw[CW_END] = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IO]  = zf_q;
                        cw[CW_J]   = zf_q;
                        cw[CW_END] = 1'b1;
                    end
`endif
                    OP_OUT: begin
                        cw[CW_AO]  = 1'b1;
                        cw[CW_OI]  = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
                    OP_HLT: begin
                        cw[CW_HLT] = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
                    default: cw[CW_END] = 1'b1;
                endcase
            end
            T3: begin
                case (op_q)
                    OP_LDA: begin
                        cw[CW_RO]  = 1'b1;
                        cw[CW_AI]  = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RO] = 1'b1;
                        cw[CW_BI] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_AO]  = 1'b1;
                        cw[CW_RI]  = 1'b1;
                        cw[CW_END] = 1'b1;
                    end
                    default: cw[CW_END] = 1'b1;
                endcase
            end
            T4: begin
                cw[CW_END] = 1'b1;
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    cw[CW_EO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                    cw[CW_FI] = 1'b1;
                    cw[CW_SU] = (op_q == OP_SUB);
                end
            end
            default: cw[CW_END] = 1'b1;
        endcase
        if (halted_q) begin
            cw = '0;
        end
    end

    // A +/- B with carry out; SUB is A + ~B + 1 so carry means no borrow
    assign alu_sum = {1'b0, a_q}
                   + {1'b0, (cw[CW_SU] ? ~b_q : b_q)}
                   + {{DATA_W{1'b0}}, cw[CW_SU]};

    // Single shared bus, one driver per step
    always_comb begin
        bus = '0;
        if (cw[CW_CO]) bus = bus | {{PAD_W{1'b0}}, pc_q};
        if (cw[CW_IO]) bus = bus | {{PAD_W{1'b0}}, arg_q};
        if (cw[CW_RO]) bus = bus | ram_rdata;
        if (cw[CW_AO]) bus = bus | a_q;
        if (cw[CW_EO]) bus = bus | alu_sum[DATA_W-1:0];
    end

    // Register next-state from the control word
    always_comb begin
        step_d    = halted_q ? step_q : (cw[CW_END] ? T0 : step_next(step_q));
        pc_d      = pc_q;
        mar_d     = mar_q;
        op_d      = op_q;
        arg_d     = arg_q;
        a_d       = a_q;
        b_d       = b_q;
        cf_d      = cf_q;
        zf_d      = zf_q;
        out_d     = out_q;
        out_vld_d = cw[CW_OI];
        halted_d  = halted_q | cw[CW_HLT];
        if (cw[CW_CE]) pc_d = pc_q + 1'b1;
        if (cw[CW_J])  pc_d = bus[ADDR_W-1:0];
        if (cw[CW_MI]) mar_d = bus[ADDR_W-1:0];
        if (cw[CW_II]) begin
            op_d  = bus[DATA_W-1 -: 4];
            arg_d = bus[ADDR_W-1:0];
        end
        if (cw[CW_AI]) a_d = bus;
        if (cw[CW_BI]) b_d = bus;
        if (cw[CW_FI]) begin
            cf_d = alu_sum[DATA_W];
            zf_d = (alu_sum[DATA_W-1:0] == '0);
        end
        if (cw[CW_OI]) out_d = bus;
    end

    // State registers, cleared asynchronously by clr
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            step_q    <= T0;
            pc_q      <= '0;
            mar_q     <= '0;
            op_q      <= '0;
            arg_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cf_q      <= 1'b0;
            zf_q      <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            step_q    <= step_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cf_q      <= cf_d;
            zf_q      <= zf_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            halted_q  <= halted_d;
        end
    end

    // Loading is only allowed while the core is held in reset or halted
    assign prog_ok = prog_we & (~clr | halted_q);

    sap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i       (clk),
        .core_we_i   (cw[CW_RI]),
        .core_addr_i (mar_q),
        .core_data_i (bus),
        .prog_we_i   (prog_ok),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .raddr_i     (mar_q),
        .rdata_o     (ram_rdata)
    );

    assign out_data  = out_q;
    assign out_valid = out_vld_q;
    assign halted    = halted_q;
    assign pc_o      = pc_q;
    assign a_o       = a_q;
    assign cf        = cf_q;
    assign zf        = zf_q;

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core (DATA_W=8, ADDR_W=4): ALU vector table,
// a scoreboard of expected OUT values, and hand sequences for timing,
// branching, PC wrap, mid-instruction reset and load-port gating.
module tb_sap_core;

    logic       clk;
    logic       clr;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc_o;
    logic [7:0] a_o;
    logic       cf;
    logic       zf;

    int errors = 0;
    int checks = 0;

    logic [7:0] img [16];
    logic [7:0] sb_q [$];

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_a;
        logic       exp_cf;
        logic       exp_zf;
    } alu_vec_t;

    alu_vec_t vecs [8];

    sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .pc_o      (pc_o),
        .a_o       (a_o),
        .cf        (cf),
        .zf        (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the next queued value
    always @(negedge clk) begin
        if (clr && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got out_data=%0d expected no pulse", out_data);
            end else begin
                chk("sb_out_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic load_img();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = img[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_to_halt();
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_data"},  {24'd0, out_data}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_halted"},    {31'd0, halted}, 32'd0);
        chk({tag, "_pc"},        {28'd0, pc_o}, 32'd0);
        chk({tag, "_a"},         {24'd0, a_o}, 32'd0);
        chk({tag, "_cf"},        {31'd0, cf}, 32'd0);
        chk({tag, "_zf"},        {31'd0, zf}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        vecs[0] = '{4'h2, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
        vecs[1] = '{4'h3, 8'd3,   8'd5,   8'd254, 1'b0, 1'b0};
        vecs[2] = '{4'h2, 8'd28,  8'd14,  8'd42,  1'b0, 1'b0};
        vecs[3] = '{4'h3, 8'd7,   8'd7,   8'd0,   1'b1, 1'b1};
        vecs[4] = '{4'h2, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
        vecs[5] = '{4'h3, 8'd10,  8'd3,   8'd7,   1'b1, 1'b0};
        vecs[6] = '{4'h2, 8'd255, 8'd1,   8'd0,   1'b1, 1'b1};
        vecs[7] = '{4'h2, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk_reset_state("rst");

        // LDA 14, ADD 15, OUT, HLT with cycle-exact timing
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'd28; img[15] = 8'd14;
        load_img();
        sb_q.push_back(8'd42);
        clr = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 11) chk("t1_out_before", {24'd0, out_data}, 32'd0);
            if (k == 12) begin
                chk("t1_out_data", {24'd0, out_data}, 32'd42);
                chk("t1_out_valid_hi", {31'd0, out_valid}, 32'd1);
            end
            if (k == 13) chk("t1_out_valid_lo", {31'd0, out_valid}, 32'd0);
            if (k == 14) chk("t1_not_halted", {31'd0, halted}, 32'd0);
            if (k == 15) chk("t1_halted", {31'd0, halted}, 32'd1);
        end
        chk("t1_a",  {24'd0, a_o}, 32'd42);
        chk("t1_cf", {31'd0, cf}, 32'd0);
        chk("t1_zf", {31'd0, zf}, 32'd0);
        chk("t1_pc", {28'd0, pc_o}, 32'd4);
        repeat (5) @(negedge clk);
        chk("t1_frozen_pc", {28'd0, pc_o}, 32'd4);
        chk("t1_frozen_a",  {24'd0, a_o}, 32'd42);
        chk("t1_out_hold",  {24'd0, out_data}, 32'd42);
        chk("t1_sb_drained", sb_q.size(), 32'd0);

        // ALU table: LDA 14, <op> 15, OUT, HLT
        for (int i = 0; i < 8; i++) begin
            enter_reset();
            clear_img();
            img[0] = 8'h1E; img[1] = {vecs[i].op, 4'hF}; img[2] = 8'hE0; img[3] = 8'hF0;
            img[14] = vecs[i].a; img[15] = vecs[i].b;
            load_img();
            sb_q.push_back(vecs[i].exp_a);
            clr = 1'b1;
            run_to_halt();
            chk("vec_a",  {24'd0, a_o}, {24'd0, vecs[i].exp_a});
            chk("vec_cf", {31'd0, cf}, {31'd0, vecs[i].exp_cf});
            chk("vec_zf", {31'd0, zf}, {31'd0, vecs[i].exp_zf});
            chk("vec_sb_drained", sb_q.size(), 32'd0);
        end

        // LDI 5, STA 13, SUB 13, JZ 6, OUT, HLT / 6: LDI 1, OUT, HLT
        enter_reset();
        clear_img();
        img[0] = 8'h55; img[1] = 8'h4D; img[2] = 8'h3D; img[3] = 8'h86;
        img[4] = 8'hE0; img[5] = 8'hF0; img[6] = 8'h51; img[7] = 8'hE0; img[8] = 8'hF0;
        load_img();
`ifdef SAP_CORE_CONDJMP_EN
        sb_q.push_back(8'd1);
`else
        sb_q.push_back(8'd0);
`endif
        clr = 1'b1;
        run_to_halt();
        chk("br_zf", {31'd0, zf}, 32'd1);
        chk("br_cf", {31'd0, cf}, 32'd1);
`ifdef SAP_CORE_CONDJMP_EN
        chk("br_out", {24'd0, out_data}, 32'd1);
        chk("br_pc",  {28'd0, pc_o}, 32'd9);
`else
        chk("br_out", {24'd0, out_data}, 32'd0);
        chk("br_pc",  {28'd0, pc_o}, 32'd6);
`endif
        chk("br_sb_drained", sb_q.size(), 32'd0);

        // JMP 15 with NOP at 15: PC wraps to 0 after fetching 15
        enter_reset();
        clear_img();
        img[0] = 8'h6F; img[15] = 8'h00;
        load_img();
        clr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) chk("wrap_pc_fetch", {28'd0, pc_o}, 32'd1);
            if (k == 3) chk("wrap_pc_jmp",   {28'd0, pc_o}, 32'd15);
            if (k == 5) chk("wrap_pc_zero",  {28'd0, pc_o}, 32'd0);
        end

        // Reset asserted during ADD T3, then a new program loaded in reset
        enter_reset();
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'd28; img[15] = 8'd14;
        load_img();
        clr = 1'b1;
        repeat (7) @(negedge clk);
        chk("mid_pc", {28'd0, pc_o}, 32'd2);
        chk("mid_a",  {24'd0, a_o}, 32'd28);
        clr = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        clear_img();
        img[0] = 8'h59; img[1] = 8'hE0; img[2] = 8'hF0;
        load_img();
        sb_q.push_back(8'd9);
        clr = 1'b1;
        // Attempt to overwrite OUT with LDI 15 while running: must be ignored
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h5F;
        @(negedge clk);
        prog_we = 1'b0;
        run_to_halt();
        chk("run_we_a",  {24'd0, a_o}, 32'd9);
        chk("run_we_pc", {28'd0, pc_o}, 32'd3);
        chk("run_we_sb_drained", sb_q.size(), 32'd0);

        // Write while halted is accepted; reset does not clear RAM
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h57;
        @(negedge clk);
        prog_we = 1'b0;
        enter_reset();
        sb_q.push_back(8'd7);
        @(negedge clk);
        clr = 1'b1;
        run_to_halt();
        chk("halt_we_a", {24'd0, a_o}, 32'd7);
        chk("halt_we_sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
